// File: rtl/hs32_flash_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hs32_flash_pkg
// Brief    : Shared states, opcodes and field widths for the SPI flash reader.
// Revision : 1.0
// ============================================================================
package hs32_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_CSH   = 3'd5
    } state_e;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;
    localparam int DATA_BITS  = 32;

    // Flash returns bytes in ascending address order; the word is little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs32_sck_gen.sv
`default_nettype none
// ============================================================================
// Module   : hs32_sck_gen
// Brief    : Mode-0 SCK divider with one-cycle-early rise/fall strobes.
// Revision : 1.0
// ============================================================================
module hs32_sck_gen
    import hs32_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_sck;
    logic       w_wrap;

    // Strobes fire in the cycle before the edge so the FSM acts on the same clk edge.
    assign w_wrap = i_en && (r_cnt == c_DIV_LAST);
    assign o_rise = w_wrap && !r_sck;
    assign o_fall = w_wrap && r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= 8'd0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= 8'd0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hs32_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : hs32_flash_reader
// Brief    : 32-bit word reader for SPI NOR flash (READ 0x03, or FAST READ
//            0x0B with 8 dummy clocks when HS32_FLASH_FAST_READ_EN is defined).
// Revision : 1.0
// ============================================================================
module hs32_flash_reader
    import hs32_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_HIGH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam logic [2:0] c_IDLE = ST_IDLE;
    localparam logic [2:0] c_CMD  = ST_CMD;
    localparam logic [2:0] c_ADDR = ST_ADDR;
    localparam logic [2:0] c_DATA = ST_DATA;
    localparam logic [2:0] c_CSH  = ST_CSH;
    localparam logic [7:0] c_CSH_LAST = 8'(CS_HIGH - 1);

`ifdef HS32_FLASH_FAST_READ_EN
    localparam logic [2:0] c_DUMMY      = ST_DUMMY;
    localparam logic [7:0] c_OPCODE     = OP_FAST_READ;
    localparam logic [2:0] c_AFTER_ADDR = c_DUMMY;
`else
    localparam logic [7:0] c_OPCODE     = OP_READ;
    localparam logic [2:0] c_AFTER_ADDR = c_DATA;
`endif

    logic [2:0]  r_state;
    logic [5:0]  r_bit_cnt;
    logic [7:0]  r_csh_cnt;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic        r_io0;
    logic        r_csb;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;

    logic        w_accept;
    logic        w_last_bit;
    logic        w_sck;
    logic        w_rise;
    logic        w_fall;
    logic        w_sck_en;

    assign req_ready  = (r_state == c_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_sck_en   = ~r_csb;
    assign flash_csb  = r_csb;
    assign flash_clk  = w_sck;
    assign flash_io0  = r_io0;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

    hs32_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .rst    (reset),
        .i_en   (w_sck_en),
        .o_sck  (w_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_last_bit = 1'b0;
        case (r_state)
            c_CMD:   w_last_bit = (r_bit_cnt == 6'(CMD_BITS - 1));
            c_ADDR:  w_last_bit = (r_bit_cnt == 6'(ADDR_BITS - 1));
`ifdef HS32_FLASH_FAST_READ_EN
            c_DUMMY: w_last_bit = (r_bit_cnt == 6'(DUMMY_BITS - 1));
`endif
            c_DATA:  w_last_bit = (r_bit_cnt == 6'(DATA_BITS - 1));
            default: w_last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_bit_cnt    <= 6'd0;
            r_csh_cnt    <= 8'd0;
            r_tx         <= 32'd0;
            r_rx         <= 32'd0;
            r_io0        <= 1'b0;
            r_csb        <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state   <= c_CMD;
                        r_csb     <= 1'b0;
                        r_bit_cnt <= 6'd0;
                        r_rx      <= 32'd0;
                        // MSB goes out immediately; the rest queues behind it.
                        r_io0     <= c_OPCODE[7];
                        r_tx      <= {c_OPCODE[6:0], req_addr, 1'b0};
                    end
                end
                c_CMD, c_ADDR: begin
                    if (w_fall) begin
                        r_tx <= {r_tx[30:0], 1'b0};
                        if (w_last_bit) begin
                            r_bit_cnt <= 6'd0;
                            r_state   <= (r_state == c_CMD) ? c_ADDR : c_AFTER_ADDR;
                            r_io0     <= (r_state == c_CMD) ? r_tx[31] : 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                            r_io0     <= r_tx[31];
                        end
                    end
                end
`ifdef HS32_FLASH_FAST_READ_EN
                c_DUMMY: begin
                    if (w_fall) begin
                        if (w_last_bit) begin
                            r_bit_cnt <= 6'd0;
                            r_state   <= c_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
`endif
                c_DATA: begin
                    if (w_rise) begin
                        r_rx <= {r_rx[30:0], flash_io1};
                    end
                    if (w_fall) begin
                        if (w_last_bit) begin
                            r_bit_cnt    <= 6'd0;
                            r_state      <= c_CSH;
                            r_csb        <= 1'b1;
                            r_csh_cnt    <= 8'd0;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= bswap32(r_rx);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                c_CSH: begin
                    if (r_csh_cnt == c_CSH_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_csh_cnt <= r_csh_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_csb   <= 1'b1;
                    r_io0   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs32_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs32_flash_reader
// Brief    : Directed bench for hs32_flash_reader (CLK_DIV=2 and CLK_DIV=1
//            instances sharing one SPI flash model); honours HS32_FLASH_FAST_READ_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_hs32_flash_reader;

    localparam int CS_HIGH = 4;
`ifdef HS32_FLASH_FAST_READ_EN
    localparam logic [7:0] EXP_OP = 8'h0B;
    localparam int N_BITS = 72;
    localparam int HDR    = 40;
`else
    localparam logic [7:0] EXP_OP = 8'h03;
    localparam int N_BITS = 64;
    localparam int HDR    = 32;
`endif
    localparam int LAT_DIV2 = 2 * N_BITS * 2;
    localparam int LAT_DIV1 = 2 * N_BITS * 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        sel = 1'b0;
    logic [23:0] req_addr = 24'd0;
    logic        miso = 1'b0;

    logic        rv_in0, rv_in1, rdy0, rdy1, rsp0, rsp1;
    logic [31:0] rd0, rd1;
    logic        csb0, csb1, sck0, sck1, mosi0, mosi1;
    logic        f_csb, f_sck, f_mosi, w_ready, w_rv;
    logic [31:0] w_rd;

    int checks = 0;
    int errors = 0;
    int proto_viol = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rv_in0  = req_valid & ~sel;
    assign rv_in1  = req_valid & sel;
    assign f_csb   = sel ? csb1  : csb0;
    assign f_sck   = sel ? sck1  : sck0;
    assign f_mosi  = sel ? mosi1 : mosi0;
    assign w_ready = sel ? rdy1  : rdy0;
    assign w_rv    = sel ? rsp1  : rsp0;
    assign w_rd    = sel ? rd1   : rd0;

    hs32_flash_reader #(.CLK_DIV(2), .CS_HIGH(CS_HIGH)) dut (
        .clk(clk), .reset(reset), .req_valid(rv_in0), .req_ready(rdy0),
        .req_addr(req_addr), .resp_valid(rsp0), .resp_data(rd0),
        .flash_csb(csb0), .flash_clk(sck0), .flash_io0(mosi0), .flash_io1(miso)
    );

    hs32_flash_reader #(.CLK_DIV(1), .CS_HIGH(CS_HIGH)) dut_div1 (
        .clk(clk), .reset(reset), .req_valid(rv_in1), .req_ready(rdy1),
        .req_addr(req_addr), .resp_valid(rsp1), .resp_data(rd1),
        .flash_csb(csb1), .flash_clk(sck1), .flash_io0(mosi1), .flash_io1(miso)
    );

    // Flash contents: CAFE at 0x10, a simple address hash everywhere else.
    function automatic logic [7:0] byte_at(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hFE;
            24'h000011: return 8'hCA;
            24'h000012: return 8'h00;
            24'h000013: return 8'h00;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    int          rise_cnt = 0;
    int          d_idx;
    logic [7:0]  m_cmd = 8'd0;
    logic [23:0] m_addr = 24'd0;
    logic [7:0]  m_byte;

    always @(negedge f_csb) rise_cnt = 0;

    always @(posedge f_sck) begin
        if (f_csb === 1'b0) begin
            if (rise_cnt < 8)       m_cmd  = {m_cmd[6:0], f_mosi};
            else if (rise_cnt < 32) m_addr = {m_addr[22:0], f_mosi};
            rise_cnt = rise_cnt + 1;
        end
    end

    always @(negedge f_sck) begin
        if (f_csb === 1'b0 && rise_cnt >= HDR && rise_cnt < HDR + 32) begin
            d_idx  = rise_cnt - HDR;
            m_byte = byte_at(m_addr + 24'(d_idx / 8));
            miso   = m_byte[7 - (d_idx % 8)];
        end
    end

    logic p_csb = 1'b1, p_sck = 1'b0, p_io0 = 1'b0, p_rv = 1'b0;
    always @(negedge clk) begin
        if (p_sck === 1'b1 && f_sck === 1'b1 && f_mosi !== p_io0) begin
            proto_viol = proto_viol + 1;
            $display("FAIL proto_io0_stable: io0 %b was %b while SCK high @%0t", f_mosi, p_io0, $time);
        end
        if (p_csb === 1'b1 && f_csb === 1'b1 && f_sck !== p_sck) begin
            proto_viol = proto_viol + 1;
            $display("FAIL proto_sck_csb_high: SCK %b->%b while CSB high @%0t", p_sck, f_sck, $time);
        end
        if (p_rv === 1'b1 && w_rv === 1'b1) begin
            proto_viol = proto_viol + 1;
            $display("FAIL proto_resp_pulse: resp_valid high 2 cycles @%0t", $time);
        end
        p_csb = f_csb; p_sck = f_sck; p_io0 = f_mosi; p_rv = w_rv;
    end

    task automatic start_req(input logic s, input logic [23:0] a, output int c_acc, output bit ok);
        sel = s; req_addr = a; req_valid = 1'b1;
        ok = 1'b0; c_acc = 0;
        #1;
        for (int i = 0; i < 600; i++) begin
            if (w_ready === 1'b1) begin
                c_acc = cyc + 1;
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_resp(input int budget, output int c_resp, output bit ok);
        ok = 1'b0; c_resp = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (w_rv === 1'b1) begin
                c_resp = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({csb0, sck0, mosi0, rsp0, rdy0} !== 5'b10001) begin
            errors++; $display("FAIL reset_pins_div2: csb/sck/io0/rv/rdy=%b want 10001", {csb0, sck0, mosi0, rsp0, rdy0});
        end
        checks++;
        if (rd0 !== 32'd0) begin
            errors++; $display("FAIL reset_data_div2: got %h want 00000000", rd0);
        end
        checks++;
        if ({csb1, sck1, mosi1, rsp1, rdy1, rd1} !== {5'b10001, 32'd0}) begin
            errors++; $display("FAIL reset_div1: pins=%b data=%h want 10001/00000000", {csb1, sck1, mosi1, rsp1, rdy1}, rd1);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({csb0, sck0, mosi0} !== 3'b100) begin
            errors++; $display("FAIL idle_pins: csb/sck/io0=%b want 100", {csb0, sck0, mosi0});
        end
    endtask

    task automatic test_single_read();
        int ca, cr, n;
        bit ok;
        start_req(1'b0, 24'h000010, ca, ok);
        req_valid = 1'b0; req_addr = 24'h555555;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: not accepted, want accept"); end
        checks++;
        if ({f_csb, f_sck, f_mosi} !== {2'b00, EXP_OP[7]}) begin
            errors++; $display("FAIL single_t1_pins: csb/sck/io0=%b want 00%b", {f_csb, f_sck, f_mosi}, EXP_OP[7]);
        end
        wait_resp(LAT_DIV2 + 50, cr, ok);
        checks++;
        if (!ok || (cr - ca) != LAT_DIV2) begin
            errors++; $display("FAIL single_latency: got %0d (seen=%0d) want %0d", cr - ca, ok, LAT_DIV2);
        end
        checks++;
        if (w_rd !== 32'h0000CAFE) begin errors++; $display("FAIL single_data: got %h want 0000cafe", w_rd); end
        checks++;
        if (m_cmd !== EXP_OP || m_addr !== 24'h000010) begin
            errors++; $display("FAIL single_mosi: cmd=%h addr=%h want %h/000010", m_cmd, m_addr, EXP_OP);
        end
        checks++;
        if (f_csb !== 1'b1 || w_ready !== 1'b0) begin
            errors++; $display("FAIL single_end_pins: csb=%b rdy=%b want 1/0", f_csb, w_ready);
        end
        n = 0;
        while (w_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n != CS_HIGH) begin errors++; $display("FAIL single_csh_ready: got %0d cycles want %0d", n, CS_HIGH); end
        checks++;
        if (w_rv !== 1'b0 || w_rd !== 32'h0000CAFE) begin
            errors++; $display("FAIL single_hold: rv=%b data=%h want 0/0000cafe", w_rv, w_rd);
        end
    endtask

    task automatic test_back_to_back();
        int ca, cr, ca2, cr2, n;
        bit ok;
        start_req(1'b0, 24'h000000, ca, ok);
        req_addr = 24'h000004;
        wait_resp(LAT_DIV2 + 50, cr, ok);
        checks++;
        if (!ok || w_rd !== 32'h59585B5A) begin
            errors++; $display("FAIL b2b_first: seen=%0d data=%h want 1/59585b5a", ok, w_rd);
        end
        n = 0;
        while (f_csb === 1'b1 && n < 50) begin @(negedge clk); n++; end
        ca2 = cyc;
        req_valid = 1'b0; req_addr = 24'hABCDEF;
        checks++;
        if (n < CS_HIGH || n >= 50) begin errors++; $display("FAIL b2b_csb_gap: got %0d cycles want >=%0d", n, CS_HIGH); end
        wait_resp(LAT_DIV2 + 50, cr2, ok);
        checks++;
        if (!ok || (cr2 - ca2) != LAT_DIV2) begin
            errors++; $display("FAIL b2b_latency2: got %0d (seen=%0d) want %0d", cr2 - ca2, ok, LAT_DIV2);
        end
        checks++;
        if (w_rd !== 32'h5D5C5F5E || m_addr !== 24'h000004) begin
            errors++; $display("FAIL b2b_second: data=%h addr=%h want 5d5c5f5e/000004", w_rd, m_addr);
        end
        repeat (CS_HIGH + 2) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int ca, cr, seen;
        bit ok;
        start_req(1'b0, 24'h000010, ca, ok);
        req_valid = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({f_csb, f_sck, w_rv, w_ready} !== 4'b1001 || w_rd !== 32'd0) begin
            errors++; $display("FAIL abort_pins: csb/sck/rv/rdy=%b data=%h want 1001/00000000", {f_csb, f_sck, w_rv, w_ready}, w_rd);
        end
        reset = 1'b0;
        seen = 0;
        repeat (300) begin @(negedge clk); if (w_rv === 1'b1) seen++; end
        checks++;
        if (seen != 0 || w_ready !== 1'b1) begin
            errors++; $display("FAIL abort_no_resp: resp pulses=%0d rdy=%b want 0/1", seen, w_ready);
        end
        start_req(1'b0, 24'h000004, ca, ok);
        req_valid = 1'b0;
        wait_resp(LAT_DIV2 + 50, cr, ok);
        checks++;
        if (!ok || w_rd !== 32'h5D5C5F5E) begin
            errors++; $display("FAIL abort_recover: seen=%0d data=%h want 1/5d5c5f5e", ok, w_rd);
        end
        repeat (CS_HIGH + 2) @(negedge clk);
    endtask

    task automatic test_clkdiv1_wrap();
        int ca, cr;
        bit ok;
        start_req(1'b1, 24'hFFFFFD, ca, ok);
        req_valid = 1'b0;
        wait_resp(LAT_DIV1 + 50, cr, ok);
        checks++;
        if (!ok || (cr - ca) != LAT_DIV1) begin
            errors++; $display("FAIL div1_latency: got %0d (seen=%0d) want %0d", cr - ca, ok, LAT_DIV1);
        end
        checks++;
        if (m_addr !== 24'hFFFFFD || m_cmd !== EXP_OP) begin
            errors++; $display("FAIL div1_mosi: cmd=%h addr=%h want %h/fffffd", m_cmd, m_addr, EXP_OP);
        end
        checks++;
        if (w_rd !== 32'h5AA5A4A7) begin errors++; $display("FAIL div1_data: got %h want 5aa5a4a7", w_rd); end
        repeat (CS_HIGH + 2) @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_reset_abort();
        test_clkdiv1_wrap();
        checks++;
        if (proto_viol != 0) begin
            errors++; $display("FAIL protocol: got %0d violations want 0", proto_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
